// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage: register file, control/ALU decode, immediate extension, ID/EX register
module instruction_decode #(
  parameter int WORD_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WORD_WIDTH-1:0]     instrD,
  input  logic [WORD_WIDTH-1:0]     PCD,
  input  logic [WORD_WIDTH-1:0]     PCPlus4D,
  input  logic                      RegWriteW,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [WORD_WIDTH-1:0]     ResultW,
  input  logic                      FlushE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1D,
  output logic [REG_ADDR_WIDTH-1:0] Rs2D,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      JumpE,
  output logic                      BranchE,
  output logic                      ALUSrcE,
  output logic                      IllegalE,
  output logic [1:0]                ResultSrcE,
  output logic [2:0]                ALUControlE,
  output logic [WORD_WIDTH-1:0]     RD1E,
  output logic [WORD_WIDTH-1:0]     RD2E,
  output logic [WORD_WIDTH-1:0]     ImmExtE,
  output logic [WORD_WIDTH-1:0]     PCE,
  output logic [WORD_WIDTH-1:0]     PCPlus4E,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int W        = WORD_WIDTH;
  localparam int A        = REG_ADDR_WIDTH;

  typedef struct packed {
    logic         reg_write;
    logic         mem_write;
    logic         jump;
    logic         branch;
    logic         alu_src;
    logic         illegal;
    logic [1:0]   result_src;
    logic [2:0]   alu_control;
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] imm_ext;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic [A-1:0] rd;
  } idex_t;

  logic [W-1:0] rf_q [NUM_REGS];
  logic [W-1:0] rf_d [NUM_REGS];
  idex_t        idex_q, idex_d;

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         funct7_b5;
  logic         dec_reg_write, dec_mem_write, dec_jump, dec_branch, dec_alu_src, dec_illegal;
  logic [1:0]   dec_imm_src, dec_result_src, dec_alu_op;
  logic [2:0]   dec_alu_control;
  logic [W-1:0] imm_ext, rd1, rd2;

  assign opcode    = instrD[6:0];
  assign funct3    = instrD[14:12];
  assign funct7_b5 = instrD[30];
  assign Rs1D      = instrD[19:15];
  assign Rs2D      = instrD[24:20];

  always_comb begin
    rf_d = rf_q;
    if (RegWriteW && RdW != '0) rf_d[RdW] = ResultW;
  end

  // Writeback data is forwarded so a same-cycle write is visible to this read.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (Rs1D != '0) rd1 = (RegWriteW && RdW == Rs1D) ? ResultW : rf_q[Rs1D];
    if (Rs2D != '0) rd2 = (RegWriteW && RdW == Rs2D) ? ResultW : rf_q[Rs2D];
  end

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_imm_src    = 2'b00;
    dec_alu_src    = 1'b0;
    dec_mem_write  = 1'b0;
    dec_result_src = 2'b00;
    dec_branch     = 1'b0;
    dec_alu_op     = 2'b00;
    dec_jump       = 1'b0;
    dec_illegal    = 1'b0;
    case (opcode)
      7'b0000011: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_result_src = 2'b01; end
      7'b0100011: begin dec_imm_src = 2'b01; dec_alu_src = 1'b1; dec_mem_write = 1'b1; end
      7'b0110011: begin dec_reg_write = 1'b1; dec_alu_op = 2'b10; end
      7'b1100011: begin dec_imm_src = 2'b10; dec_branch = 1'b1; dec_alu_op = 2'b01; end
      7'b0010011: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = 2'b10; end
      7'b1101111: begin
        dec_reg_write  = 1'b1;
        dec_imm_src    = 2'b11;
        dec_result_src = 2'b10;
        dec_jump       = 1'b1;
      end
      default:    dec_illegal = 1'b1;
    endcase
  end

  // Only R-type (opcode[5]=1) turns funct7[5] into subtract; I-type immediates reuse that bit.
  always_comb begin
    dec_alu_control = 3'b000;
    case (dec_alu_op)
      2'b01: dec_alu_control = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  dec_alu_control = (opcode[5] & funct7_b5) ? 3'b001 : 3'b000;
          3'b010:  dec_alu_control = 3'b101;
          3'b110:  dec_alu_control = 3'b011;
          3'b111:  dec_alu_control = 3'b010;
          default: dec_alu_control = 3'b000;
        endcase
      end
      default: dec_alu_control = 3'b000;
    endcase
  end

  always_comb begin
    imm_ext = '0;
    case (dec_imm_src)
      2'b00: imm_ext = {{(W-12){instrD[31]}}, instrD[31:20]};
      2'b01: imm_ext = {{(W-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
      2'b10: imm_ext = {{(W-12){instrD[31]}}, instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      2'b11: imm_ext = {{(W-20){instrD[31]}}, instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write   = dec_reg_write;
      idex_d.mem_write   = dec_mem_write;
      idex_d.jump        = dec_jump;
      idex_d.branch      = dec_branch;
      idex_d.alu_src     = dec_alu_src;
      idex_d.illegal     = dec_illegal;
      idex_d.result_src  = dec_result_src;
      idex_d.alu_control = dec_alu_control;
      idex_d.rd1         = rd1;
      idex_d.rd2         = rd2;
      idex_d.imm_ext     = imm_ext;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
      idex_d.rd          = instrD[11:7];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      idex_q <= idex_d;
      rf_q   <= rf_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign IllegalE    = idex_q.illegal;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign RdE         = idex_q.rd;
endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - scoreboard bench for the instruction_decode stage
module tb_instruction_decode;
  logic        clk;
  logic        reset;
  logic [31:0] instrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        illegal;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } e_t;

  int          vectors = 0;
  int          fails   = 0;
  e_t          exp_q[$];
  logic [31:0] ref_rf [32];

  instruction_decode #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic e_t observe();
    e_t o;
    o = '{RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE,
          RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};
    return o;
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'b000:  return is_sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx, input logic we,
                                          input logic [4:0] wd, input logic [31:0] wr);
    if (idx == 5'd0) return 32'd0;
    if (we && wd == idx) return wr;
    return ref_rf[idx];
  endfunction

  // Reference decode written per instruction format, independent of the RTL's field tables.
  function automatic e_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                               input logic we, input logic [4:0] wd, input logic [31:0] wr);
    e_t e;
    logic [31:0] imm_i;
    e = '0;
    imm_i = {{20{ins[31]}}, ins[31:20]};
    e.pc  = pc;
    e.pc4 = pc4;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.rd1 = rf_read(ins[19:15], we, wd, wr);
    e.rd2 = rf_read(ins[24:20], we, wd, wr);
    e.imm = imm_i;
    case (ins[6:0])
      7'b0000011: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; end
      7'b0100011: begin
        e.mem_write = 1; e.alu_src = 1;
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b0110011: begin e.reg_write = 1; e.alu_ctrl = alu_ref(ins[14:12], ins[30]); end
      7'b1100011: begin
        e.branch = 1; e.alu_ctrl = 3'b001;
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0010011: begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = alu_ref(ins[14:12], 1'b0); end
      7'b1101111: begin
        e.reg_write = 1; e.jump = 1; e.result_src = 2'b10;
        e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic we, input logic [4:0] wd,
                       input logic [31:0] wr, input logic flush);
    logic [31:0] pc;
    pc        = $urandom & 32'hFFFF_FFFC;
    instrD    = ins;
    PCD       = pc;
    PCPlus4D  = pc + 32'd4;
    RegWriteW = we;
    RdW       = wd;
    ResultW   = wr;
    FlushE    = flush;
    exp_q.push_back(flush ? e_t'('0) : model(ins, pc, pc + 32'd4, we, wd, wr));
    if (we && wd != 5'd0) ref_rf[wd] = wr;
    @(posedge clk);
    #1;
    RegWriteW = 1'b0;
    FlushE    = 1'b0;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
  endtask

  task automatic test_reset();
    e_t got, exp;
    reset = 1'b0;
    clear_ref();
    for (int n = 0; n < 4; n++) begin
      instrD = $urandom; PCD = $urandom; PCPlus4D = $urandom; ResultW = $urandom;
      RdW = 5'($urandom); RegWriteW = 1'b1; FlushE = 1'($urandom);
      exp_q.push_back('0);
      @(posedge clk); #1;
      got = observe(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin fails++; $display("FAIL reset_hold[%0d]: got %h expected %h", n, got, exp); end
    end
    RegWriteW = 1'b0; FlushE = 1'b0;
    reset = 1'b1;
    for (int i = 1; i < 32; i++) begin
      apply(r_type(7'd0, 5'(i), 5'(i), 3'b000, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
      got = observe(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp || RD1E !== 32'd0) begin
        fails++; $display("FAIL reset_rf_x%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_write_read();
    e_t got, exp;
    apply(32'h0000_0013, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    void'(exp_q.pop_front());
    apply(32'h0050_00B3, 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin fails++; $display("FAIL write_read: got %h expected %h", got, exp); end
    vectors++;
    if (RD2E !== 32'hDEAD_BEEF || RD1E !== 32'd0 || ALUControlE !== 3'b000 || RegWriteE !== 1'b1 || RdE !== 5'd1) begin
      fails++; $display("FAIL write_read_fields: got rd1=%h rd2=%h alu=%b rw=%b rd=%0d expected rd1=0 rd2=deadbeef alu=000 rw=1 rd=1",
                        RD1E, RD2E, ALUControlE, RegWriteE, RdE);
    end
  endtask

  task automatic test_bypass();
    e_t got, exp;
    apply(r_type(7'd0, 5'd5, 5'd5, 3'b000, 5'd2), 1'b1, 5'd5, 32'hCAFE_F00D, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || RD1E !== 32'hCAFE_F00D || RD2E !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL bypass: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_x0();
    e_t got, exp;
    apply(32'h0000_0013, 1'b1, 5'd0, 32'h1234_5678, 1'b0);
    void'(exp_q.pop_front());
    apply(r_type(7'd0, 5'd0, 5'd0, 3'b000, 5'd3), 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || RD1E !== 32'd0 || RD2E !== 32'd0) begin
      fails++; $display("FAIL x0_read: got %h expected %h", got, exp);
    end
    apply(r_type(7'd0, 5'd0, 5'd0, 3'b000, 5'd3), 1'b1, 5'd0, 32'h1234_5678, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || RD1E !== 32'd0) begin
      fails++; $display("FAIL x0_no_bypass: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_decode();
    e_t got, exp;
    logic [31:0] vec [10];
    apply(32'h0000_0013, 1'b1, 5'd9, 32'h0000_1000, 1'b0);
    void'(exp_q.pop_front());
    instrD = 32'hFFC4_A303; #1;
    vectors++;
    if (Rs1D !== 5'd9 || Rs2D !== 5'd28) begin
      fails++; $display("FAIL rs_comb: got rs1=%0d rs2=%0d expected rs1=9 rs2=28", Rs1D, Rs2D);
    end
    apply(32'hFFC4_A303, 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || ImmExtE !== 32'hFFFF_FFFC || ResultSrcE !== 2'b01 || ALUSrcE !== 1'b1 || Rs1E !== 5'd9 || RdE !== 5'd6) begin
      fails++; $display("FAIL decode_lw: got %h expected %h", got, exp);
    end
    apply(32'h4031_00B3, 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || ALUControlE !== 3'b001) begin
      fails++; $display("FAIL decode_sub: got %h expected %h", got, exp);
    end
    apply(b_type(13'h1FF8, 5'd2, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || ImmExtE !== 32'hFFFF_FFF8 || BranchE !== 1'b1 || ALUControlE !== 3'b001) begin
      fails++; $display("FAIL decode_beq: got %h expected %h", got, exp);
    end
    vec[0] = s_type(12'h804, 5'd9, 5'd2);
    vec[1] = j_type(21'h1FF_FF0, 5'd1);
    vec[2] = j_type(21'h00_0804, 5'd1);
    vec[3] = r_type(7'd0, 5'd3, 5'd9, 3'b010, 5'd4);
    vec[4] = r_type(7'd0, 5'd3, 5'd9, 3'b110, 5'd4);
    vec[5] = r_type(7'd0, 5'd3, 5'd9, 3'b111, 5'd4);
    vec[6] = r_type(7'h20, 5'd3, 5'd9, 3'b100, 5'd4);
    vec[7] = i_type(12'hC00, 5'd9, 3'b000, 5'd7, 7'b0010011);
    vec[8] = i_type(12'h7FF, 5'd9, 3'b010, 5'd7, 7'b0010011);
    vec[9] = i_type(12'h432, 5'd9, 3'b111, 5'd7, 7'b0010011);
    for (int i = 0; i < 10; i++) begin
      apply(vec[i], 1'b0, 5'd0, 32'd0, 1'b0);
      got = observe(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin fails++; $display("FAIL decode_vec[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_flush();
    e_t got, exp;
    apply(32'h0050_00B3, 1'b1, 5'd12, 32'h0BAD_F00D, 1'b1);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin fails++; $display("FAIL flush_bubble: got %h expected %h", got, exp); end
    apply(r_type(7'd0, 5'd12, 5'd5, 3'b000, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || RD2E !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL flush_resume: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_illegal();
    e_t got, exp;
    apply(32'h0000_007F, 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || IllegalE !== 1'b1 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0) begin
      fails++; $display("FAIL illegal: got %h expected %h", got, exp);
    end
    apply(32'h0050_00B3, 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || IllegalE !== 1'b0) begin
      fails++; $display("FAIL illegal_clear: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    e_t got, exp;
    apply(32'h0050_00B3, 1'b1, 5'd7, 32'h7777_7777, 1'b0);
    void'(exp_q.pop_front());
    #3;
    reset = 1'b0;
    #1;
    got = observe(); vectors++;
    if (got !== e_t'('0)) begin fails++; $display("FAIL mid_reset_async: got %h expected 0", got); end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_ref();
    apply(r_type(7'd0, 5'd7, 5'd5, 3'b000, 5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
    got = observe(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp || RD1E !== 32'd0 || RD2E !== 32'd0) begin
      fails++; $display("FAIL mid_reset_rf: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    e_t got, exp;
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: ins = i_type(12'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0000011);
        1: ins = s_type(12'($urandom), 5'($urandom), 5'($urandom));
        2: ins = r_type($urandom_range(0, 1) ? 7'h20 : 7'h00, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom));
        3: ins = b_type({12'($urandom), 1'b0}, 5'($urandom), 5'($urandom));
        4: ins = i_type(12'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), 7'b0010011);
        5: ins = j_type({20'($urandom), 1'b0}, 5'($urandom));
        default: ins = $urandom;
      endcase
      apply(ins, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 7) == 0));
      got = observe(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin fails++; $display("FAIL back_to_back[%0d] instr %h: got %h expected %h", n, ins, got, exp); end
    end
  endtask

  initial begin
    reset = 1'b0; instrD = '0; PCD = '0; PCPlus4D = '0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0; FlushE = 1'b0;
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_decode();
    test_flush();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Decode stage of the 5-stage RV32I pipeline; consumes the fetch stage's D-side outputs (instrD, PCD, PCPlus4D).
- Holds the 32x32 register file, written back from W.
- Decodes control signals and sign-extends immediates.
- Registers everything into the ID/EX pipeline register for the execute stage, with flush for bubbles.

Parameters:
- WORD_WIDTH, 32, datapath/instruction width.
- REG_ADDR_WIDTH, 5, register index width; the file holds 2**REG_ADDR_WIDTH registers.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low (0 = reset).
- instrD  input  WORD_WIDTH  instruction from fetch.
- PCD  input  WORD_WIDTH  PC of instrD.
- PCPlus4D  input  WORD_WIDTH  PCD+4.
- RegWriteW  input  1  writeback enable.
- RdW  input  REG_ADDR_WIDTH  writeback destination.
- ResultW  input  WORD_WIDTH  writeback data.
- FlushE  input  1  load a bubble into ID/EX.
- Rs1D, Rs2D  output  REG_ADDR_WIDTH  combinational instrD[19:15], instrD[24:20], for the hazard unit.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE  output  1  registered controls.
- ResultSrcE  output  2  registered result select.
- ALUControlE  output  3  registered ALU op.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  WORD_WIDTH  registered data.
- Rs1E, Rs2E, RdE  output  REG_ADDR_WIDTH  registered register indices.

Behaviour:
- Reset (reset=0, async): all E outputs = 0 and all registers x0..x31 = 0. Held while reset=0.
- Register file write: rising clk edge, when RegWriteW=1 and RdW!=0, stores ResultW. Writes to x0 are ignored, and x0 always reads 0.
- Register file read: combinational at index Rs1D/Rs2D.
  - Bypass: if RegWriteW=1, RdW==Rs and Rs!=0, the read returns ResultW in the same cycle (write-then-read).
- Main decoder, by opcode instrD[6:0]. Fields: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump.
  - 0000011 lw: 1, 00, 1, 0, 01, 0, 00, 0.
  - 0100011 sw: 0, 01, 1, 1, 00, 0, 00, 0.
  - 0110011 R: 1, 00, 0, 0, 00, 0, 10, 0.
  - 1100011 beq: 0, 10, 0, 0, 00, 1, 01, 0.
  - 0010011 I-ALU: 1, 00, 1, 0, 00, 0, 10, 0.
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1.
  - Any other opcode: all controls 0, Illegal=1. Otherwise Illegal=0.
- ALU decoder:
  - ALUOp 00 -> 000 (add).
  - ALUOp 01 -> 001 (sub).
  - ALUOp 10, by funct3:
    - 000: 001 if opcode[5]&funct7[5], else 000.
    - 010 -> 101 (slt).
    - 110 -> 011 (or).
    - 111 -> 010 (and).
    - Others -> 000.
- Immediate extension, sign taken from instrD[31]:
  - 00 I-type: instr[31:20].
  - 01 S-type: {instr[31:25], instr[11:7]}.
  - 10 B-type: {instr[7], instr[30:25], instr[11:8], 0}.
  - 11 J-type: {instr[19:12], instr[20], instr[30:21], 0}.
- Field mapping: RdE captures instrD[11:7] regardless of opcode.
- ID/EX register: latency 1 cycle; every E output captures its D-side value on the rising edge.
  - FlushE=1 at the edge loads all E outputs with 0 (NOP bubble), taking priority over capture.
  - A register-file write in the same edge as a flush still occurs.
- Reset asserted mid-operation clears the ID/EX register and the register file immediately. Operation resumes on the first edge after reset releases.

Test Plan:
- Reset: hold reset=0 with random inputs -> all E outputs 0. After release, reading x1..x31 returns 0.
- Write/read:
  - RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, then instrD=0x005000B3 (add x1,x0,x5) -> next edge RD2E=0xDEADBEEF, RD1E=0, ALUControlE=000, RegWriteE=1, RdE=1.
  - Same-cycle write and read of x5 -> identical values via the bypass.
- x0: RegWriteW=1, RdW=0, ResultW=0x12345678, then read x0 -> 0.
- Decode:
  - lw x6,-4(x9) = 0xFFC4A303 -> ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, Rs1E=9, RdE=6.
  - sub 0x403100B3 -> ALUControlE=001.
  - beq with offset -8 -> ImmExtE=0xFFFFFFF8, BranchE=1.
- Flush: valid add in D with FlushE=1 -> all E outputs 0. Next cycle with FlushE=0, the instruction is captured normally.
- Illegal: instrD=0x0000007F -> IllegalE=1, RegWriteE=0, MemWriteE=0. A following legal instruction -> IllegalE=0.
